// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit with HI/LO result registers.
//            It handles signed and unsigned MULT and DIV. Each of these takes
//            WIDTH cycles and computes one bit per cycle. MTHI and MTLO write
//            HI or LO in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CW-1:0]    r_cnt;

    // Iteration working registers. For multiply they hold the running upper
    // product half and the multiplier being shifted out. For divide they hold
    // the partial remainder and the quotient being shifted in.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_a;        // raw dividend, reported as HI on divide-by-zero
    logic             r_is_mul;
    logic             r_neg_res;  // negate product / quotient at the end
    logic             r_neg_rem;  // remainder takes the sign of the dividend
    logic             r_div0;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_busy;
    logic             w_last;
    logic             w_iter_op;
    logic             w_signed;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_r;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // Operand decode for a request presented this cycle
    assign w_iter_op = ~op[2];
    assign w_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign w_mag_a   = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_mag_b   = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One shift-add multiply step
    assign w_mul_sum = {1'b0, r_acc_hi} + ({1'b0, r_opb} & {(WIDTH+1){r_acc_lo[0]}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

    // One restoring divide step. The difference fits in WIDTH bits whenever
    // it is kept, because the remainder is always smaller than the divisor.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_r     = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_opb) : w_div_shift[WIDTH-1:0];
    assign w_div_q     = {r_acc_lo[WIDTH-2:0], w_div_ge};

    assign w_step_hi = r_is_mul ? w_mul_hi : w_div_r;
    assign w_step_lo = r_is_mul ? w_mul_lo : w_div_q;
    assign w_prod    = {w_mul_hi, w_mul_lo};

    // Final sign fix-up and special cases applied on the last step's outcome
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_is_mul) begin
            {w_res_hi, w_res_lo} = r_neg_res ? (~w_prod + 1'b1) : w_prod;
        end else if (r_div0) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else begin
            w_res_lo = r_neg_res ? (~w_div_q + 1'b1) : w_div_q;
            w_res_hi = r_neg_rem ? (~w_div_r + 1'b1) : w_div_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: only iterative ops leave IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start && w_iter_op) w_state_next = S_RUN;
            S_RUN:   if (w_last)             w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode from state and counter
    always_comb begin
        w_busy = (r_state == S_RUN);
        w_last = (r_state == S_RUN) && (r_cnt == C_LAST);
    end

    // Datapath: operand capture, iteration, and HI/LO updates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opb     <= '0;
            r_a       <= '0;
            r_is_mul  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_busy) begin
                if (w_last) begin
                    r_cnt  <= '0;
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                end
            end else if (start) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        r_cnt     <= '0;
                        r_acc_hi  <= '0;
                        r_acc_lo  <= w_mag_b;
                        r_opb     <= w_mag_a;
                        r_a       <= a;
                        r_is_mul  <= 1'b1;
                        r_neg_res <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= 1'b0;
                        r_div0    <= 1'b0;
                    end
                    OP_DIV, OP_DIVU: begin
                        r_cnt     <= '0;
                        r_acc_hi  <= '0;
                        r_acc_lo  <= w_mag_a;
                        r_opb     <= w_mag_b;
                        r_a       <= a;
                        r_is_mul  <= 1'b0;
                        r_neg_res <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_signed && a[WIDTH-1];
                        r_div0    <= (b == '0);
                    end
                    OP_MTHI: r_hi <= a;
                    OP_MTLO: r_lo <= a;
                    default: ;
                endcase
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit (WIDTH=32) using directed vectors
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];
    string       sb_nm[$];
    logic        prev_done = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Directed vectors: op, a, b, expected hi, expected lo, back-to-back flag
    localparam int NV = 9;
    logic [2:0]  v_op [NV] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV,
                               OP_DIV, OP_DIVU, OP_MULT, OP_DIV};
    logic [31:0] v_a  [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000007,
                               32'h80000000, 32'h00000007, 32'd100, 32'h7FFFFFFF,
                               32'hFFFFFFF9};
    logic [31:0] v_b  [NV] = '{32'h00000005, 32'hFFFFFFFF, 32'h00000002, 32'h00000000,
                               32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'h80000000,
                               32'h00000000};
    logic [31:0] v_hi [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000007,
                               32'h00000000, 32'h00000001, 32'h00000002, 32'hC0000000,
                               32'hFFFFFFF9};
    logic [31:0] v_lo [NV] = '{32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'h80000000, 32'hFFFFFFFD, 32'h0000000E, 32'h80000000,
                               32'hFFFFFFFF};
    bit          v_b2b[NV] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    string       v_nm [NV] = '{"mult_neg", "multu_max", "div_b2b", "divu_by0", "div_ovf",
                               "div_negdiv", "divu_100_7", "mult_minmax", "div_by0_neg"};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the operands so that
    // anything sampled after the accepting edge would corrupt the result
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_res, input logic [31:0] eh, input logic [31:0] el,
                         input string nm);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (expect_res) begin
            sb_q.push_back({eh, el});
            sb_nm.push_back(nm);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        a     = ~x;
        b     = ~y;
    endtask

    // Count busy cycles until done; returns at the negedge of the done cycle
    task automatic wait_done(input int exp_busy, input string nm);
        int  cyc  = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) cyc++;
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        chk({nm, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
        chk({nm, "_busy_in_done"}, 64'(busy), 64'd0);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (done) begin
            chk("done_pulse_width", 64'(prev_done), 64'd0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got hi=%h lo=%h required no done", hi, lo);
            end else begin
                logic [63:0] e;
                string       nm;
                e  = sb_q.pop_front();
                nm = sb_nm.pop_front();
                chk({nm, "_hi"}, 64'(hi), 64'(e[63:32]));
                chk({nm, "_lo"}, 64'(lo), 64'(e[31:0]));
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table, including a start issued in the done cycle
        for (int i = 0; i < NV; i++) begin
            if (!v_b2b[i]) @(negedge clk);
            issue(v_op[i], v_a[i], v_b[i], 1'b1, v_hi[i], v_lo[i], v_nm[i]);
            wait_done(32, v_nm[i]);
        end

        // MTHI during RUN is ignored and HI/LO keep their previous values
        @(negedge clk);
        issue(OP_MULT, 32'd3, 32'd4, 1'b1, 32'h0, 32'hC, "mult_inflight");
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        chk("inflight_hi_hold", 64'(hi), 64'hFFFFFFF9);
        chk("inflight_lo_hold", 64'(lo), 64'hFFFFFFFF);
        wait_done(27, "mult_inflight");

        // MTHI / MTLO / reserved op
        @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi",   64'(hi),   64'h12345678);
        chk("mthi_lo",   64'(lo),   64'h0000000C);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'hCAFEBABE;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_hi",   64'(hi),   64'h12345678);
        chk("mtlo_lo",   64'(lo),   64'hCAFEBABE);
        start = 1'b1;
        op    = 3'b110;
        a     = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0;
        chk("op110_hi",   64'(hi),   64'h12345678);
        chk("op110_lo",   64'(lo),   64'hCAFEBABE);
        chk("op110_busy", 64'(busy), 64'd0);

        // Reset during RUN cycle 10 of DIVU 100/7 aborts with no done
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, "divu_abort");
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi",   64'(hi),   64'd0);
        chk("abort_lo",   64'(lo),   64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rst_prio_busy2", 64'(busy), 64'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only on rising clk edges.
REQ-005 Port: op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (no state change).
REQ-006 Port: a  input  WIDTH  operand 1 (multiplicand / dividend / MTHI-MTLO source).
REQ-007 Port: b  input  WIDTH  operand 2 (multiplier / divisor).
REQ-008 Port: busy  output  1  iterative operation in progress.
REQ-009 Port: done  output  1  one-cycle pulse; HI/LO hold a new MULT/DIV result.
REQ-010 Port: hi  output  WIDTH  HI register (product upper half / remainder).
REQ-011 Port: lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-012 Accept: start=1 and busy=0 on a rising edge; a, b, op latched internally at that edge; start while busy=1 ignored, no effect.
REQ-013 States: IDLE, RUN; IDLE->RUN on accepted MULT/MULTU/DIV/DIVU; RUN->IDLE after WIDTH RUN cycles; MTHI/MTLO/ignored ops stay in IDLE.
REQ-014 busy=1 exactly while in RUN: accept at edge N -> busy=1 in cycles N+1..N+WIDTH, busy=0 from cycle N+WIDTH+1.
REQ-015 Iteration: one bit per cycle (shift-add multiply, restoring divide on magnitudes); internal counter 0..WIDTH-1.
REQ-016 hi/lo hold previous values throughout RUN; no intermediate value visible; both updated only on the edge leaving RUN.
REQ-017 done=1 for exactly the one cycle after the RUN->IDLE edge (cycle N+WIDTH+1), else 0.
REQ-018 start=1 in the done cycle is accepted (back-to-back); then busy=1 and done=1 coexist for that cycle only if... no: done cycle has busy=0, next cycle busy=1, done=0.
REQ-019 MULT: {hi,lo} = signed(a) * signed(b), full 2*WIDTH-bit two's-complement product.
REQ-020 MULTU: {hi,lo} = unsigned a * unsigned b, full 2*WIDTH bits.
REQ-021 DIV: lo = signed quotient truncated toward zero; hi = remainder with sign of dividend (a = lo*b + hi).
REQ-022 DIVU: lo = a / b, hi = a mod b, unsigned.
REQ-023 Divide by zero (DIV or DIVU, b=0): lo = all ones, hi = a; normal WIDTH-cycle latency, done pulses.
REQ-024 Signed overflow (DIV, a = most-negative, b = all ones): lo = a (most-negative), hi = 0.
REQ-025 MTHI: accepted edge writes hi <= a; lo unchanged; busy and done stay 0.
REQ-026 MTLO: accepted edge writes lo <= a; hi unchanged; busy and done stay 0.
REQ-027 Operand inputs a/b/op changing during RUN have no effect on the result.

Reset
REQ-028 reset=1 on a rising edge: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0.
REQ-029 reset mid-RUN aborts the operation; no done pulse, no HI/LO write from the aborted op.
REQ-030 reset has priority over start in the same cycle; start ignored.

Verification (WIDTH=32)
REQ-031 MULT a=FFFFFFFD (-3), b=00000005 -> busy 32 cycles, then hi=FFFFFFFF, lo=FFFFFFF1, done one cycle.
REQ-032 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; back-to-back DIV -7/2 started in done cycle -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 DIVU a=00000007, b=0 -> lo=FFFFFFFF, hi=00000007; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-034 MULT in flight, start with MTHI at cycle 5 of RUN -> ignored; hi/lo unchanged until result edge; then MTHI a=12345678 -> hi=12345678 next cycle, busy/done 0.
REQ-035 reset asserted at RUN cycle 10 of DIVU 100/7 -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
